alu_mac_pipe: RTL and testbench
===============================

Name: alu_mac_pipe

Overview:
- Parametrised successor to the 8-bit multiply-add ALU.
- Computes a signed fixed-point multiply, then adds either a registered bias or a running accumulator.
- Three-stage pipeline with a valid/ready handshake on both sides.
- Saturating output with an overflow flag; sits between the operand-fetch stage and register writeback.

Parameters:
- BUS_WIDTH, 8, operand/result width (signed two's complement, >= 4).
- FRAC_BITS, 0, fractional bits of operands and result (0 = integer; must be < BUS_WIDTH).
- ACC_GUARD, 4, extra integer guard bits on the internal accumulator.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  pipeline can accept a beat.
- mode  in  2  00 MULADD (a*b+bias), 01 MAC (acc+=a*b), 10 ADD (a+b+bias), 11 MUL (a*b).
- data_a  in  BUS_WIDTH  operand A.
- data_b  in  BUS_WIDTH  operand B.
- imm  in  BUS_WIDTH  bias value, written when bias_we.
- bias_we  in  1  load imm into the bias register.
- acc_clr  in  1  clear the accumulator.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- result  out  BUS_WIDTH  saturated result.
- sat_flag  out  1  result was clipped (qualified by out_valid).

Behaviour:
- Reset (rst_n low, async) clears:
  - all stage valid bits, so out_valid=0;
  - result=0, sat_flag=0;
  - bias register=0;
  - accumulator=0.
  - in_ready is 1 the first cycle after reset.
- Handshake:
  - A beat is accepted when in_valid && in_ready. Output transfers when out_valid && out_ready.
  - in_ready = !s3_valid || out_ready. All three stages advance together on that enable (global stall); there are no bubbles-collapse requirements.
  - result and sat_flag hold stable while out_valid && !out_ready.
- Latency: a beat accepted at cycle N appears on result with out_valid=1 at cycle N+3 if not stalled. Throughput is one per cycle.
- S1: register data_a, data_b, mode.
- S2: product P = a*b, full 2*BUS_WIDTH signed, arithmetic-shifted right by FRAC_BITS (truncate toward minus infinity). In ADD mode, S2 forwards sign-extended (a+b) instead of P.
- S3:
  - MULADD: sum = P + bias (bias sign-extended and aligned to the same FRAC_BITS).
  - ADD: sum = (a+b) + bias.
  - MUL: sum = P.
  - MAC: sum = acc + P. acc <= sum clipped to BUS_WIDTH+ACC_GUARD bits.
  - Output: saturate sum to [-2^(BUS_WIDTH-1), 2^(BUS_WIDTH-1)-1]. sat_flag=1 when clipped.
- Bias register:
  - Written on any cycle with bias_we, independent of the handshake.
  - A beat entering S3 in the same cycle as the write uses the old bias; a beat one cycle behind uses the new value.
- Accumulator:
  - Updated only when a MAC beat advances out of S3.
  - acc_clr is sampled at the input with the beat when in_valid && in_ready; otherwise it applies immediately.
  - A beat-tagged clear on a MAC beat means acc = 0 + P for that beat.
  - Non-MAC beats never modify acc.
- Internal accumulator overflow: saturates at the ACC_GUARD-extended range and never wraps.
- Stall: no stage register, acc or sat_flag changes while stalled, except a bias_we write.
- Reset mid-operation discards all in-flight beats; no partial output is produced.

Decomposition:
- Shared package alu_pkg holds:
  - typedef alu_mode_e {MODE_MULADD, MODE_MAC, MODE_ADD, MODE_MUL};
  - the sat_clip function (width-parametrised via a localparam in the caller);
  - stage struct typedefs for valid, mode, operands and the clr tag.
- One natural sub-module: sfixed_sat_adder, a parametrised signed adder with saturation and an overflow output, instanced in S3.

Test Plan (all with BUS_WIDTH=8, FRAC_BITS=0 unless noted):
- MULADD, bias_we imm=5, a=3, b=4, out_ready=1 -> result=17 at accept+3, sat_flag=0.
- MUL, a=100, b=2 -> result=127, sat_flag=1. Then a=-100, b=2 -> result=-128, sat_flag=1.
- MAC stream a=10,b=10 four beats, first beat with acc_clr=1 -> results 100, 127 (sat), 127, 127. Internal acc is 200, 300, 400 clipped to 12-bit (max 2047), and sat_flag=1 from beat 2 onward.
- Backpressure: 5 back-to-back ADD beats, out_ready=0 for cycles 4-7 -> in_ready=0 during the stall, result held constant, all 5 results delivered in order with no loss or duplication.
- FRAC_BITS=4: a=0x18 (1.5), b=0x20 (2.0), bias=0 -> result=0x30 (3.0). Also a=0xF8 (-0.5), b=0x11 -> result=0xF7 (floor).
- Assert rst_n low mid-stream with 2 beats in flight -> out_valid=0 asynchronously, acc=0, bias=0, and no stale output after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and helpers for the multiply-add / MAC pipeline.
package alu_pkg;

    // Operation selector carried down the pipeline with each beat.
    typedef enum logic [1:0] {
        MODE_MULADD = 2'b00,
        MODE_MAC    = 2'b01,
        MODE_ADD    = 2'b10,
        MODE_MUL    = 2'b11
    } alu_mode_e;

    // Widest intermediate the clip helper handles; callers sign-extend into it.
    localparam int SAT_MAX_W = 64;

    // Per-stage control: beat valid, its operation and the accumulator-clear tag.
    typedef struct packed {
        logic      valid;
        alu_mode_e mode;
        logic      clr;
    } stage_ctrl_t;

    // Clip a signed value into the range of a w-bit two's complement number.
    function automatic logic signed [SAT_MAX_W-1:0] sat_clip(
        input logic signed [SAT_MAX_W-1:0] v,
        input int                          w
    );
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/sfixed_sat_adder.sv
// Signed adder returning the exact sum plus a copy saturated to OUT_W bits.
// IN_W + 1 must not exceed alu_pkg::SAT_MAX_W.
module sfixed_sat_adder
    import alu_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8
) (
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [IN_W-1:0]  b,
    output logic signed [IN_W:0]    sum,
    output logic signed [OUT_W-1:0] y,
    output logic                    ovf
);

    logic signed [SAT_MAX_W-1:0] wide;

    // Full-precision add, then clip; ovf marks any value that was clipped.
    always_comb begin
        sum  = (IN_W + 1)'(a) + (IN_W + 1)'(b);
        wide = SAT_MAX_W'(sum);
        y    = OUT_W'(sat_clip(wide, OUT_W));
        ovf  = (sat_clip(wide, OUT_W) != wide);
    end

endmodule

// File: rtl/alu_mac_pipe.sv
// Three-stage signed fixed-point multiply-add / MAC pipeline with saturation.
// S1 registers operands, S2 forms the product (or a+b), S3 adds bias or the
// accumulator and registers the saturated result.
//
// Handshake: a beat is taken when in_valid && in_ready, a result leaves when
// out_valid && out_ready. in_ready = !out_valid || out_ready and every stage
// advances on that one enable, so a stalled output freezes the whole pipe and
// result/sat_flag stay stable until accepted.
module alu_mac_pipe
    import alu_pkg::*;
#(
    parameter int BUS_WIDTH = 8,
    parameter int FRAC_BITS = 0,
    parameter int ACC_GUARD = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           mode,
    input  logic [BUS_WIDTH-1:0] data_a,
    input  logic [BUS_WIDTH-1:0] data_b,
    input  logic [BUS_WIDTH-1:0] imm,
    input  logic                 bias_we,
    input  logic                 acc_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] result,
    output logic                 sat_flag
);

    localparam int PW    = 2 * BUS_WIDTH;
    localparam int ACC_W = BUS_WIDTH + ACC_GUARD;
    localparam int OW    = (PW > ACC_W) ? PW : ACC_W;

    stage_ctrl_t                 s1_ctrl;
    stage_ctrl_t                 s2_ctrl;
    logic signed [BUS_WIDTH-1:0] s1_a;
    logic signed [BUS_WIDTH-1:0] s1_b;
    logic signed [PW-1:0]        s2_val;
    logic                        s3_valid;
    logic signed [BUS_WIDTH-1:0] bias;
    logic signed [ACC_W-1:0]     acc;

    logic                        adv;
    logic                        take;
    logic signed [PW-1:0]        prod;
    logic signed [PW-1:0]        prod_sh;
    logic signed [PW-1:0]        sum_ab;
    logic signed [OW-1:0]        op_x;
    logic signed [OW-1:0]        op_y;
    logic signed [OW:0]          sum_full;
    logic signed [BUS_WIDTH-1:0] sat_y;
    logic                        sat_ovf;

    assign adv       = !s3_valid || out_ready;
    assign in_ready  = adv;
    assign take      = in_valid && adv;
    assign out_valid = s3_valid;

    // S1: capture the incoming beat and its clear tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_ctrl <= '0;
            s1_a    <= '0;
            s1_b    <= '0;
        end else if (adv) begin
            s1_ctrl.valid <= in_valid;
            s1_ctrl.mode  <= alu_mode_e'(mode);
            s1_ctrl.clr   <= acc_clr;
            s1_a          <= data_a;
            s1_b          <= data_b;
        end
    end

    // S2 datapath: full product floored to FRAC_BITS, and the plain sum for ADD.
    always_comb begin
        prod    = PW'(s1_a) * PW'(s1_b);
        prod_sh = prod >>> FRAC_BITS;
        sum_ab  = PW'(s1_a) + PW'(s1_b);
    end

    // S2: register the product (or a+b) with the beat's control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_ctrl <= '0;
            s2_val  <= '0;
        end else if (adv) begin
            s2_ctrl <= s1_ctrl;
            s2_val  <= (s1_ctrl.mode == MODE_ADD) ? sum_ab : prod_sh;
        end
    end

    // S3 operand select: bias, accumulator (zero on a tagged clear) or nothing.
    always_comb begin
        op_x = OW'(s2_val);
        case (s2_ctrl.mode)
            MODE_MULADD, MODE_ADD: op_y = OW'(bias);
            MODE_MAC:              op_y = s2_ctrl.clr ? '0 : OW'(acc);
            default:               op_y = '0;
        endcase
    end

    sfixed_sat_adder #(
        .IN_W  (OW),
        .OUT_W (BUS_WIDTH)
    ) u_sat_add (
        .a   (op_x),
        .b   (op_y),
        .sum (sum_full),
        .y   (sat_y),
        .ovf (sat_ovf)
    );

    // S3: register the saturated result; only real beats touch result/sat_flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid <= 1'b0;
            result   <= '0;
            sat_flag <= 1'b0;
        end else if (adv) begin
            s3_valid <= s2_ctrl.valid;
            if (s2_ctrl.valid) begin
                result   <= sat_y;
                sat_flag <= sat_ovf;
            end
        end
    end

    // Bias register: written whenever bias_we is high, regardless of flow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias <= '0;
        end else if (bias_we) begin
            bias <= imm;
        end
    end

    // Accumulator: untagged clear acts at once; MAC beats leaving S2 fold in
    // their sum, clipped to the guard-extended range instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (acc_clr && !take) begin
            acc <= '0;
        end else if (adv && s2_ctrl.valid && (s2_ctrl.mode == MODE_MAC)) begin
            acc <= ACC_W'(sat_clip(SAT_MAX_W'(sum_full), ACC_W));
        end
    end

endmodule

// File: tb/tb_alu_mac_pipe.sv
// Bench for alu_mac_pipe: an integer instance and a Q4 instance share one
// input stream; a reference model fills expected queues that a negedge
// monitor drains.
module tb_alu_mac_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] data_a = '0;
    logic [7:0] data_b = '0;
    logic [7:0] imm = '0;
    logic       bias_we = 1'b0;
    logic       acc_clr = 1'b0;
    logic       out_ready = 1'b1;

    logic       in_ready0, out_valid0, sat0;
    logic [7:0] result0;
    logic       in_ready1, out_valid1, sat1;
    logic [7:0] result1;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q0[$];
    logic [8:0] exp_q1[$];
    longint     m_acc[2];
    longint     m_bias = 0;
    bit         hold_low = 1'b0;
    bit         bp_rand = 1'b0;

    // Clock
    always #5 clk = ~clk;

    alu_mac_pipe #(.BUS_WIDTH(8), .FRAC_BITS(0), .ACC_GUARD(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .mode(mode), .data_a(data_a), .data_b(data_b), .imm(imm),
        .bias_we(bias_we), .acc_clr(acc_clr), .out_valid(out_valid0),
        .out_ready(out_ready), .result(result0), .sat_flag(sat0)
    );

    alu_mac_pipe #(.BUS_WIDTH(8), .FRAC_BITS(4), .ACC_GUARD(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .mode(mode), .data_a(data_a), .data_b(data_b), .imm(imm),
        .bias_we(bias_we), .acc_clr(acc_clr), .out_valid(out_valid1),
        .out_ready(out_ready), .result(result1), .sat_flag(sat1)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint clamp(input longint v, input longint lo, input longint hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint sx(input logic [7:0] v);
        return longint'(signed'(v));
    endfunction

    // Reference: exact integer arithmetic, floor division by 2^frac, clamp.
    function automatic logic [8:0] model_beat(input int inst, input int frac,
                                              input logic [1:0] md, input logic [7:0] a,
                                              input logic [7:0] b, input bit clr);
        longint av, bv, d, prod, p, sum, r;
        logic [63:0] rv;
        av = sx(a);
        bv = sx(b);
        d = longint'(1) << frac;
        prod = av * bv;
        p = prod / d;
        if (prod < 0 && (prod % d) != 0) p = p - 1;
        case (md)
            2'd0: sum = p + m_bias;
            2'd1: begin
                sum = (clr ? 64'sd0 : m_acc[inst]) + p;
                m_acc[inst] = clamp(sum, -2048, 2047);
            end
            2'd2: sum = av + bv + m_bias;
            default: sum = p;
        endcase
        r = clamp(sum, -128, 127);
        rv = r;
        return {r != sum, rv[7:0]};
    endfunction

    // Output ready: forced low, random, or always high.
    always @(posedge clk) begin
        #1;
        out_ready = hold_low ? 1'b0 : (bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    // Scoreboard monitor: every presented result must match the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready0", longint'(in_ready0), longint'(!out_valid0 || out_ready));
            if (out_valid0) begin
                if (exp_q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out0_spurious: got 0x%0h expected no output", {sat0, result0});
                end else begin
                    check("result0", longint'({sat0, result0}), longint'(exp_q0[0]));
                    if (out_ready) void'(exp_q0.pop_front());
                end
            end
            if (out_valid1) begin
                if (exp_q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out1_spurious: got 0x%0h expected no output", {sat1, result1});
                end else begin
                    check("result1", longint'({sat1, result1}), longint'(exp_q1[0]));
                    if (out_ready) void'(exp_q1.pop_front());
                end
            end
        end
    end

    // Driver: hold a beat until accepted, then queue its expected results.
    task automatic send(input logic [1:0] md, input logic [7:0] a, input logic [7:0] b,
                        input bit clr);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        mode = md;
        data_a = a;
        data_b = b;
        acc_clr = clr;
        do begin
            @(negedge clk);
            ok = in_ready0;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
        end else begin
            exp_q0.push_back(model_beat(0, 0, md, a, b, clr));
            exp_q1.push_back(model_beat(1, 4, md, a, b, clr));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        acc_clr = 1'b0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_q0", longint'(exp_q0.size()), 0);
        check("drain_q1", longint'(exp_q1.size()), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic set_bias(input logic [7:0] v);
        bias_we = 1'b1;
        imm = v;
        @(posedge clk);
        #1;
        bias_we = 1'b0;
        m_bias = sx(v);
    endtask

    task automatic clear_now();
        in_valid = 1'b0;
        acc_clr = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        m_acc[0] = 0;
        m_acc[1] = 0;
    endtask

    // Single beat into an empty, unstalled pipe: check latency and fixed values.
    task automatic send_expect(input logic [1:0] md, input logic [7:0] a, input logic [7:0] b,
                               input bit clr, input logic [8:0] e0, input logic [8:0] e1);
        send(md, a, b, clr);
        in_valid = 1'b0;
        acc_clr = 1'b0;
        repeat (2) @(negedge clk);
        check("latency_early", longint'(out_valid0), 0);
        @(negedge clk);
        check("latency_valid", longint'(out_valid0), 1);
        check("fixed0", longint'({sat0, result0}), longint'(e0));
        check("fixed1", longint'({sat1, result1}), longint'(e1));
        @(posedge clk);
        #1;
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1, "watchdog");
    end

    initial begin
        m_acc[0] = 0;
        m_acc[1] = 0;

        // Reset state
        #1;
        check("rst_out_valid", longint'(out_valid0), 0);
        check("rst_result", longint'(result0), 0);
        check("rst_sat", longint'(sat0), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_after_rst", longint'(in_ready0), 1);
        @(posedge clk);
        #1;

        // MULADD with bias 5
        set_bias(8'd5);
        send_expect(2'd0, 8'd3, 8'd4, 1'b0, 9'h011, 9'h005);

        // MUL saturation both directions
        send_expect(2'd3, 8'd100, 8'd2, 1'b0, 9'h17F, 9'h00C);
        send_expect(2'd3, 8'h9C, 8'd2, 1'b0, 9'h180, 9'h0F3);

        // MAC stream, first beat tagged clear
        send_expect(2'd1, 8'd10, 8'd10, 1'b1, 9'h064, 9'h006);
        send_expect(2'd1, 8'd10, 8'd10, 1'b0, 9'h17F, 9'h00C);
        send_expect(2'd1, 8'd10, 8'd10, 1'b0, 9'h17F, 9'h012);
        send_expect(2'd1, 8'd10, 8'd10, 1'b0, 9'h17F, 9'h018);
        // Drive acc past its guard range, then pull it back: no wrap
        send_expect(2'd1, 8'd127, 8'd127, 1'b0, 9'h17F, 9'h17F);
        send_expect(2'd1, 8'h80, 8'h10, 1'b0, 9'h0FF, 9'h17F);

        // Fixed-point cases with zero bias
        set_bias(8'd0);
        send_expect(2'd0, 8'h18, 8'h20, 1'b0, 9'h17F, 9'h030);
        send_expect(2'd0, 8'hF8, 8'h11, 1'b0, 9'h180, 9'h0F7);

        // Backpressure: five ADD beats with a forced stall
        set_bias(8'd3);
        fork
            begin
                for (int i = 0; i < 5; i++) send(2'd2, 8'(10 * i + 1), 8'(i + 2), 1'b0);
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                hold_low = 1'b1;
                repeat (4) @(posedge clk);
                hold_low = 1'b0;
            end
        join
        drain();

        // Randomized bursts; clear tags only in bursts without backpressure
        for (int bst = 0; bst < 16; bst++) begin
            bp_rand = bst[0];
            set_bias(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 1) clear_now();
            for (int k = 0; k < 20; k++) begin
                if ($urandom_range(0, 4) == 0) begin
                    in_valid = 1'b0;
                    acc_clr = 1'b0;
                    @(posedge clk);
                    #1;
                end
                send(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 255)),
                     (bst[0] == 0) && ($urandom_range(0, 5) == 0));
            end
            drain();
        end
        bp_rand = 1'b0;

        // Reset with two beats in flight
        set_bias(8'd9);
        send(2'd1, 8'd7, 8'd7, 1'b0);
        send(2'd0, 8'd2, 8'd2, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_valid", longint'(out_valid0), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid0", longint'(out_valid0), 0);
        check("async_rst_valid1", longint'(out_valid1), 0);
        exp_q0.delete();
        exp_q1.delete();
        m_acc[0] = 0;
        m_acc[1] = 0;
        m_bias = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("no_stale_output", longint'(out_valid0), 0);
        send_expect(2'd0, 8'd3, 8'd4, 1'b0, 9'h00C, 9'h000);
        send_expect(2'd1, 8'd5, 8'd5, 1'b0, 9'h019, 9'h001);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
